// File: rtl/adc_link_pkg.sv
// Shared constants and serializer state encoding for the ADC row link.
// Imported by the frame serializer and its bench.
package adc_link_pkg;

    localparam int BITS_ADC    = 12;
    localparam int FRAME_WORDS = 32;
    localparam int SOF_BIT     = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/adc_frame_serializer_fifo.sv
// Single-clock FIFO with show-ahead read data.
// Accepts a push while full when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign level = count;
    assign rdata = mem[rd_ptr];
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_serializer.sv
// Buffers strobed ADC words and shifts them out 12 bits MSB first,
// tracking 32-word frame alignment on the read side.
module adc_frame_serializer
    import adc_link_pkg::*;
#(
    parameter int BITS_ADC    = adc_link_pkg::BITS_ADC,
    parameter int FIFO_DEPTH  = 8,
    parameter int FRAME_WORDS = adc_link_pkg::FRAME_WORDS
) (
    input  logic                        clk_50M,
    input  logic                        rst_n,
    input  logic [BITS_ADC:0]           p_data,
    input  logic                        p_strobe,
    output logic                        s_data,
    output logic                        data_valid,
    output logic                        frame_done,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int IW = $clog2(FRAME_WORDS);
    localparam int CW = $clog2(BITS_ADC);
    localparam logic [CW-1:0] LAST_BIT = CW'(BITS_ADC - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_WORDS - 1);

    logic [BITS_ADC:0]   fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                want;
    logic                drop;
    logic                in_sync;
    logic                sof_in;
    logic                sof_out;

    ser_state_t          state;
    ser_state_t          state_nxt;
    logic [BITS_ADC-1:0] shifter;
    logic [CW-1:0]       bit_cnt;
    logic [IW-1:0]       rd_idx;
    logic [IW-1:0]       idx_base;
    logic [IW-1:0]       idx_next;
    logic                cur_last;
    logic                done_pend;
    logic                last_bit;
    logic                load;
    logic                err;

    assign sof_in  = p_data[SOF_BIT];
    assign sof_out = fifo_rdata[SOF_BIT];

    // A word is wanted once aligned, or when it is itself a SOF
    assign want = p_strobe && (in_sync || sof_in);
    assign push = want && (!fifo_full || pop);
    assign drop = want && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (BITS_ADC + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_50M),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (p_data),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Write-side alignment and sticky overflow; a drop forces a resync
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            in_sync  <= 1'b0;
            overflow <= 1'b0;
        end else if (drop) begin
            in_sync  <= 1'b0;
            overflow <= 1'b1;
        end else if (push && sof_in) begin
            in_sync  <= 1'b1;
        end
    end

    // Serializer state register
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pop/load decisions and frame-index bookkeeping for the next state
    always_comb begin
        pop       = 1'b0;
        load      = 1'b0;
        err       = 1'b0;
        idx_base  = rd_idx;
        state_nxt = state;
        last_bit  = (state == SHIFT) && (bit_cnt == LAST_BIT);
        unique case (state)
            IDLE:  pop = !fifo_empty && !done_pend;
            SHIFT: pop = !fifo_empty && last_bit;
        endcase
        if (sof_out) begin
            idx_base = '0;
        end
        if (pop) begin
            if (!sof_out && rd_idx == '0) begin
                err = 1'b1;
            end else begin
                load = 1'b1;
                err  = sof_out && (rd_idx != '0);
            end
        end
        if (load) begin
            state_nxt = SHIFT;
        end else if (last_bit) begin
            state_nxt = IDLE;
        end
    end

    assign idx_next = (idx_base == LAST_IDX) ? '0 : idx_base + 1'b1;

    // Shifter, bit counter, frame index and registered link outputs
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            shifter    <= '0;
            bit_cnt    <= '0;
            rd_idx     <= '0;
            cur_last   <= 1'b0;
            done_pend  <= 1'b0;
            s_data     <= 1'b0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            s_data     <= (state == SHIFT) && shifter[BITS_ADC-1];
            data_valid <= (state == SHIFT);
            frame_err  <= err;
            done_pend  <= last_bit && cur_last;
            frame_done <= done_pend;
            if (load) begin
                shifter  <= fifo_rdata[BITS_ADC-1:0];
                bit_cnt  <= '0;
                rd_idx   <= idx_next;
                cur_last <= (idx_base == LAST_IDX);
            end else if (state == SHIFT) begin
                shifter  <= {shifter[BITS_ADC-2:0], 1'b0};
                bit_cnt  <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Randomized and directed bench for adc_frame_serializer with a
// word-level reference model of the sync and frame rules.
module tb_adc_frame_serializer;

    logic        clk_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_strobe = 1'b0;
    logic [12:0] p_data = '0;
    logic        s_data;
    logic        data_valid;
    logic        frame_done;
    logic        frame_err;
    logic        overflow;
    logic [3:0]  fifo_level;

    int vectors = 0;
    int miscompares = 0;

    always #10 clk_50M = ~clk_50M;

    adc_frame_serializer dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .p_data     (p_data),
        .p_strobe   (p_strobe),
        .s_data     (s_data),
        .data_valid (data_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    // Link monitor: rebuilds words from the serial stream
    int          cyc = 0;
    int          bits_cnt = 0;
    int          nvalid = 0;
    int          run = 0;
    int          ndone = 0;
    int          nerr = 0;
    int          both_hi = 0;
    int          broken = 0;
    int          last_end = 0;
    logic [11:0] acc = '0;
    logic [11:0] got[$];
    int          runs[$];
    int          done_lag[$];

    always @(negedge clk_50M) begin
        cyc++;
        if (data_valid) begin
            nvalid++;
            run++;
            acc = {acc[10:0], s_data};
            bits_cnt++;
            if (bits_cnt == 12) begin
                got.push_back(acc);
                bits_cnt = 0;
                last_end = cyc;
            end
        end else begin
            if (run > 0) runs.push_back(run);
            run = 0;
            if (bits_cnt != 0) broken++;
            bits_cnt = 0;
        end
        if (frame_done) begin
            ndone++;
            done_lag.push_back(cyc - last_end);
        end
        if (frame_err) nerr++;
        if (frame_done && frame_err) both_hi++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic strobe(input logic [12:0] w);
        p_data   = w;
        p_strobe = 1'b1;
        @(negedge clk_50M);
        p_strobe = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (s_data !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_s_data: got %b want 0", s_data);
        end
        vectors++;
        if (data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 0", data_valid);
        end
        vectors++;
        if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulses: got %b%b want 00", frame_done, frame_err);
        end
        vectors++;
        if (overflow !== 1'b0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_fifo: got ovf=%b lvl=%0d want 0/0", overflow, fifo_level);
        end
    endtask

    task automatic test_single_word();
        logic [11:0] code;
        int          base;
        int          d0;
        code = 12'hABC;
        do_reset();
        base = got.size();
        d0   = ndone;
        strobe(13'h1ABC);
        vectors++;
        if (fifo_level !== 4'd1) begin
            miscompares++;
            $display("FAIL single_push_level: got %0d want 1", fifo_level);
        end
        tick(1);
        vectors++;
        if (data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_latency_early: got valid=%b want 0", data_valid);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1);
            vectors++;
            if (data_valid !== 1'b1 || s_data !== code[11-i]) begin
                miscompares++;
                $display("FAIL single_bit%0d: got v=%b d=%b want v=1 d=%b",
                         11 - i, data_valid, s_data, code[11-i]);
            end
        end
        tick(1);
        vectors++;
        if (data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_tail: got valid=%b want 0", data_valid);
        end
        tick(4);
        vectors++;
        if (ndone != d0 || got.size() != base + 1) begin
            miscompares++;
            $display("FAIL single_summary: got done=%0d words=%0d want 0/1",
                     ndone - d0, got.size() - base);
        end
    endtask

    task automatic test_frame();
        int base;
        int v0;
        int d0;
        int e0;
        do_reset();
        base = got.size();
        v0 = nvalid;
        d0 = ndone;
        e0 = nerr;
        for (int i = 0; i < 32; i++) begin
            strobe((i == 0) ? 13'h1000 : 13'(i));
            tick(15);
        end
        tick(20);
        vectors++;
        if (got.size() - base != 32) begin
            miscompares++;
            $display("FAIL frame_words: got %0d want 32", got.size() - base);
        end else begin
            for (int i = 0; i < 32; i++) begin
                vectors++;
                if (got[base+i] !== 12'(i)) begin
                    miscompares++;
                    $display("FAIL frame_word%0d: got %h want %h", i, got[base+i], 12'(i));
                end
            end
        end
        vectors++;
        if (nvalid - v0 != 384) begin
            miscompares++;
            $display("FAIL frame_bits: got %0d want 384", nvalid - v0);
        end
        vectors++;
        if (ndone - d0 != 1 || done_lag[done_lag.size()-1] != 1) begin
            miscompares++;
            $display("FAIL frame_done: got n=%0d lag=%0d want 1/1",
                     ndone - d0, done_lag[done_lag.size()-1]);
        end
        vectors++;
        if (nerr != e0) begin
            miscompares++;
            $display("FAIL frame_noerr: got %0d want 0", nerr - e0);
        end
    endtask

    task automatic test_resync_err();
        logic [12:0] w;
        logic [11:0] expq[$];
        int          base;
        int          d0;
        int          e0;
        int          b0;
        base = got.size();
        d0 = ndone;
        e0 = nerr;
        b0 = both_hi;
        for (int k = 0; k < 42; k++) begin
            w = {1'(k == 0 || k == 10), 12'($urandom)};
            if (k == 41) begin
                tick(20);
                vectors++;
                if (ndone != d0) begin
                    miscompares++;
                    $display("FAIL resync_early_done: got %0d want 0", ndone - d0);
                end
            end
            strobe(w);
            expq.push_back(w[11:0]);
            tick(15);
        end
        tick(20);
        vectors++;
        if (got.size() - base != 42) begin
            miscompares++;
            $display("FAIL resync_words: got %0d want 42", got.size() - base);
        end else begin
            for (int i = 0; i < 42; i++) begin
                vectors++;
                if (got[base+i] !== expq[i]) begin
                    miscompares++;
                    $display("FAIL resync_word%0d: got %h want %h", i, got[base+i], expq[i]);
                end
            end
        end
        vectors++;
        if (nerr - e0 != 1 || ndone - d0 != 1 || both_hi != b0) begin
            miscompares++;
            $display("FAIL resync_pulses: got err=%0d done=%0d both=%0d want 1/1/0",
                     nerr - e0, ndone - d0, both_hi - b0);
        end
    endtask

    task automatic test_unsynced();
        int v0;
        int lvl_bad;
        do_reset();
        v0 = nvalid;
        lvl_bad = 0;
        strobe(13'h055);
        if (fifo_level !== 4'd0) lvl_bad++;
        tick(3);
        strobe(13'h0AA);
        if (fifo_level !== 4'd0) lvl_bad++;
        tick(30);
        vectors++;
        if (lvl_bad != 0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("FAIL unsynced_level: got lvl=%0d bad=%0d want 0", fifo_level, lvl_bad);
        end
        vectors++;
        if (nvalid != v0) begin
            miscompares++;
            $display("FAIL unsynced_valid: got %0d want 0", nvalid - v0);
        end
    endtask

    task automatic test_random();
        logic [12:0] stim[$];
        logic [11:0] expq[$];
        logic        sync;
        logic        sof;
        int          idx;
        int          e_done;
        int          e_err;
        int          len;
        int          base;
        int          d0;
        int          e0;
        int          b0;
        int          r0;
        int          bad_runs;
        sync = 1'b0;
        idx = 0;
        e_done = 0;
        e_err = 0;
        bad_runs = 0;
        repeat ($urandom_range(0, 2)) stim.push_back({1'b0, 12'($urandom)});
        for (int s = 0; s < 3; s++) begin
            len = (s == 0) ? $urandom_range(32, 38) : $urandom_range(1, 40);
            stim.push_back({1'b1, 12'($urandom)});
            for (int k = 1; k < len; k++) stim.push_back({1'b0, 12'($urandom)});
        end
        foreach (stim[k]) begin
            sof = stim[k][12];
            if (!sync && !sof) continue;
            sync = 1'b1;
            if (sof) begin
                if (idx != 0) e_err++;
                idx = 0;
            end else if (idx == 0) begin
                e_err++;
                continue;
            end
            expq.push_back(stim[k][11:0]);
            idx++;
            if (idx == 32) begin
                e_done++;
                idx = 0;
            end
        end
        do_reset();
        base = got.size();
        d0 = ndone;
        e0 = nerr;
        b0 = both_hi;
        r0 = runs.size();
        foreach (stim[k]) begin
            strobe(stim[k]);
            tick($urandom_range(12, 19));
        end
        tick(40);
        vectors++;
        if (got.size() - base != expq.size()) begin
            miscompares++;
            $display("FAIL random_words: got %0d want %0d", got.size() - base, expq.size());
        end else begin
            foreach (expq[i]) begin
                vectors++;
                if (got[base+i] !== expq[i]) begin
                    miscompares++;
                    $display("FAIL random_word%0d: got %h want %h", i, got[base+i], expq[i]);
                end
            end
        end
        vectors++;
        if (ndone - d0 != e_done || nerr - e0 != e_err) begin
            miscompares++;
            $display("FAIL random_pulses: got done=%0d err=%0d want %0d/%0d",
                     ndone - d0, nerr - e0, e_done, e_err);
        end
        for (int i = r0; i < runs.size(); i++) begin
            if (runs[i] % 12 != 0) bad_runs++;
        end
        vectors++;
        if (bad_runs != 0 || both_hi != b0) begin
            miscompares++;
            $display("FAIL random_shape: got bad_runs=%0d both=%0d want 0/0",
                     bad_runs, both_hi - b0);
        end
    endtask

    task automatic test_overflow();
        logic [12:0] w[10];
        int          peak;
        int          base;
        int          d0;
        int          e0;
        do_reset();
        base = got.size();
        d0 = ndone;
        e0 = nerr;
        peak = 0;
        for (int k = 0; k < 10; k++) w[k] = {1'(k == 0), 12'($urandom)};
        p_strobe = 1'b1;
        for (int k = 0; k < 10; k++) begin
            p_data = w[k];
            @(negedge clk_50M);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        p_strobe = 1'b0;
        tick(130);
        vectors++;
        if (peak != 8) begin
            miscompares++;
            $display("FAIL ovf_peak: got %0d want 8", peak);
        end
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flag: got %b want 1", overflow);
        end
        vectors++;
        if (got.size() - base != 9) begin
            miscompares++;
            $display("FAIL ovf_words: got %0d want 9", got.size() - base);
        end else begin
            for (int i = 0; i < 9; i++) begin
                vectors++;
                if (got[base+i] !== w[i][11:0]) begin
                    miscompares++;
                    $display("FAIL ovf_word%0d: got %h want %h", i, got[base+i], w[i][11:0]);
                end
            end
        end
        vectors++;
        if (runs.size() == 0 || runs[runs.size()-1] != 108) begin
            miscompares++;
            $display("FAIL ovf_contiguous: got run=%0d want 108",
                     (runs.size() == 0) ? 0 : runs[runs.size()-1]);
        end
        strobe({1'b0, 12'($urandom)});
        tick(30);
        vectors++;
        if (got.size() - base != 9 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_resync: got words=%0d ovf=%b want 9/1",
                     got.size() - base, overflow);
        end
        vectors++;
        if (ndone != d0 || nerr != e0) begin
            miscompares++;
            $display("FAIL ovf_pulses: got done=%0d err=%0d want 0/0", ndone - d0, nerr - e0);
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] w0;
        logic [12:0] w1;
        int          k;
        int          base;
        int          v0;
        int          br0;
        w0 = {1'b1, 12'($urandom)};
        w1 = {1'b1, 12'($urandom)};
        br0 = broken;
        strobe(w0);
        strobe({1'b0, 12'($urandom)});
        strobe({1'b0, 12'($urandom)});
        k = 0;
        while (data_valid !== 1'b1 && k < 10) begin
            tick(1);
            k++;
        end
        vectors++;
        if (data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_start_timeout: got valid=%b want 1", data_valid);
        end
        tick(6);
        vectors++;
        if (data_valid !== 1'b1 || s_data !== w0[5]) begin
            miscompares++;
            $display("FAIL mid_bit5: got v=%b d=%b want v=1 d=%b", data_valid, s_data, w0[5]);
        end
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        vectors++;
        if (data_valid !== 1'b0 || s_data !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got v=%b d=%b lvl=%0d ovf=%b want 0/0/0/0",
                     data_valid, s_data, fifo_level, overflow);
        end
        tick(1);
        base = got.size();
        v0 = nvalid;
        strobe({1'b0, 12'($urandom)});
        tick(40);
        vectors++;
        if (nvalid != v0 || broken - br0 != 1) begin
            miscompares++;
            $display("FAIL mid_quiet: got bits=%0d broken=%0d want 0/1", nvalid - v0, broken - br0);
        end
        strobe(w1);
        tick(20);
        vectors++;
        if (got.size() - base != 1 || got[got.size()-1] !== w1[11:0]) begin
            miscompares++;
            $display("FAIL mid_resume: got n=%0d last=%h want 1/%h",
                     got.size() - base, got[got.size()-1], w1[11:0]);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_frame();
        test_resync_err();
        test_unsynced();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
